codec_tdm_link: RTL
===================

CODEC_TDM_LINK -- requirements
Module: codec_tdm_link

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, 256x sample rate (12.288 MHz gives 48 kHz).
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port sdin, input, 1 bit: serial TDM data from the codec ADC.
REQ-004 SHALL have port sdout, output, 1 bit: serial TDM data to the codec DAC.
REQ-005 SHALL have port bick, output, 1 bit: bit clock, clk/2.
REQ-006 SHALL have port lrck, output, 1 bit: frame sync pulse.
REQ-007 SHALL have port sample_clk, output, 1 bit: frame-rate clock for the audio cores (clk/256).
REQ-008 SHALL have ports sample_in0..sample_in3, output, signed 16 bits each: last completed ADC channels 0..3.
REQ-009 SHALL have ports sample_out0..sample_out3, input, signed 16 bits each: DAC channels 0..3 from the audio core.

Function
REQ-010 SHALL keep an 8-bit free-running counter cnt (0..255, wraps 255->0); bit index b = cnt[7:1] (0..127), slot ch = b[6:5], offset k = b[4:0].
REQ-011 SHALL drive bick = cnt[0] and sample_clk = ~cnt[7], both registered: sample_clk high for cnt 0..127, low for 128..255.
REQ-012 SHALL drive lrck high exactly while b == 0 (2 clk cycles per frame), low otherwise.
REQ-013 SHALL place each channel MSB-first in a 32-bit slot: bit (16-k) of ch at k = 1..16; zero at k = 0 and at k = 17..31.
REQ-014 SHALL change sdout only on clk edges where cnt becomes even (bick falling), so data is stable across the bick rising edge.
REQ-015 SHALL sample sdin on the clk edge where cnt leaves an odd value, for k = 1..16 only, into a 16-bit shift register for slot ch; sdin at other offsets SHALL be ignored.
REQ-016 SHALL do both of the following on the edge where cnt wraps 255->0: copy the 4 capture registers to sample_in0..3 (sample_clk rises on the same edge); latch sample_out0..3 into 4 transmit registers for the frame starting.
REQ-017 SHALL give fixed latency: ADC data captured in frame N appears on sample_in at the start of frame N+1; sample_out latched at the start of frame N is transmitted in frame N.
REQ-018 SHALL hold sample_in and transmit registers stable for the whole frame; changes on sample_out mid-frame SHALL have no effect until the next wrap.
REQ-019 SHALL pass the -32768 and 32767 extremes bit-exact in both directions, with no saturation or scaling.

Reset
REQ-020 SHALL, while rst is high, set cnt=0, bick=0, lrck=0, sdout=0, sample_clk=0, sample_in0..3=0, and capture/transmit registers=0.
REQ-021 SHALL, on the first edge with rst low, start a new frame at cnt=0 with lrck high, and transmit zeros in that first frame.
REQ-022 SHALL, on reset asserted mid-frame, discard partial capture: sample_in stays 0 until the first complete post-reset frame ends.

Configuration
REQ-023 SHALL, with macro CODEC_TDM_LOOPBACK_EN defined, take the capture path from the internally generated sdout instead of the sdin pin; sample_in(n) then equals the sample_out(n) latched one frame earlier, and sdin is unused.
REQ-024 SHALL, without CODEC_TDM_LOOPBACK_EN, capture from sdin with no loopback logic present.

Verification
REQ-025 SHALL cover: reset, then run 256 clk -> lrck high only for cnt 0..1; bick toggles every clk; sample_clk rises exactly at each 255->0 wrap.
REQ-026 SHALL cover: sample_out0..3 = 0x8000, 0x7FFF, 0x1234, 0xFFFF -> sdout slots carry those bits MSB-first at offsets 1..16 and zeros elsewhere.
REQ-027 SHALL cover: codec model drives sdin with ch0..3 = 0x0001, 0xA5A5, 0x8000, 0x7FFF in frame N -> sample_in0..3 show those values from the wrap ending frame N, held 256 clk.
REQ-028 SHALL cover: sample_out0 changed from 0x1111 to 0x2222 at cnt=100 -> frame transmits 0x1111; the next frame transmits 0x2222.
REQ-029 SHALL cover: rst asserted at cnt=150 for 3 clk -> all outputs 0, the next frame starts with lrck high, and sample_in stays 0 until that frame completes.
REQ-030 SHALL cover, with CODEC_TDM_LOOPBACK_EN: sample_out = 0x4321, 0xBEEF, 0x0000, 0x8001 -> sample_in equals the same values one frame later, with sdin tied to 1.

Source files
------------

// File: rtl/codec_tdm_link.sv
// codec_tdm_link: 4-slot x 16-bit TDM codec link with a 256-clk frame; define CODEC_TDM_LOOPBACK_EN to capture from the internal sdout instead of sdin
module codec_tdm_link (
  input  logic               clk,
  input  logic               rst,
  input  logic               sdin,
  output logic               sdout,
  output logic               bick,
  output logic               lrck,
  output logic               sample_clk,
  output logic signed [15:0] sample_in0,
  output logic signed [15:0] sample_in1,
  output logic signed [15:0] sample_in2,
  output logic signed [15:0] sample_in3,
  input  logic signed [15:0] sample_out0,
  input  logic signed [15:0] sample_out1,
  input  logic signed [15:0] sample_out2,
  input  logic signed [15:0] sample_out3
);
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] b_q, b_d;
  logic [4:0] k_q, k_d;
  logic [3:0] tx_idx;
  logic [3:0][15:0] cap_q, tx_q, in_q;
  logic run_q, wrap, cap_en, cap_bit;
  logic bick_q, lrck_q, sclk_q, sdout_q, sdout_d;
  // first edge after reset holds cnt at 0 so the frame opens with a full lrck pulse
  assign cnt_d = run_q ? cnt_q + 8'd1 : 8'd0;
  assign wrap = run_q && cnt_q == 8'hff;
  assign b_q = cnt_q[7:1];
  assign k_q = b_q[4:0];
  assign b_d = cnt_d[7:1];
  assign k_d = b_d[4:0];
  assign tx_idx = 4'(5'd16 - k_d);
  assign sdout_d = cnt_d[0] ? sdout_q : (k_d != 5'd0 && k_d <= 5'd16) ? tx_q[b_d[6:5]][tx_idx] : 1'b0;
  assign cap_en = run_q && cnt_q[0] && k_q != 5'd0 && k_q <= 5'd16;
`ifdef CODEC_TDM_LOOPBACK_EN
  logic unused_sdin;
  assign unused_sdin = sdin;
  assign cap_bit = sdout_q;
`else
  assign cap_bit = sdin;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= 8'd0;
      bick_q <= 1'b0;
      lrck_q <= 1'b0;
      sclk_q <= 1'b0;
      sdout_q <= 1'b0;
      cap_q <= '0;
      tx_q <= '0;
      in_q <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
      bick_q <= cnt_d[0];
      lrck_q <= b_d == 7'd0;
      sclk_q <= ~cnt_d[7];
      sdout_q <= sdout_d;
      if (cap_en) cap_q[b_q[6:5]] <= {cap_q[b_q[6:5]][14:0], cap_bit};
      if (wrap) begin
        in_q <= cap_q;
        tx_q <= {sample_out3, sample_out2, sample_out1, sample_out0};
      end
    end
  end
  assign sdout = sdout_q;
  assign bick = bick_q;
  assign lrck = lrck_q;
  assign sample_clk = sclk_q;
  assign sample_in0 = in_q[0];
  assign sample_in1 = in_q[1];
  assign sample_in2 = in_q[2];
  assign sample_in3 = in_q[3];
endmodule
